mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 15; cycles in a BUSY state without mem_ack before the access is aborted.
REQ-002 Parameter STARVE_MAX, default 4; consecutive data grants allowed while if_req waits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  instruction-fetch request; held until if_ready.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetch data, valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 if_stall  out  1  if_req & ~if_ready.
REQ-010 d_rd  in  1  data load request (MemRead); held until d_ready.
REQ-011 d_wr  in  1  data store request (MemWrite); held until d_ready.
REQ-012 d_addr / d_wdata  in  32 / 32  data address and store data.
REQ-013 d_rdata  out  32  load data, valid while d_ready=1.
REQ-014 d_ready  out  1  one-cycle data completion pulse.
REQ-015 d_stall  out  1  (d_rd|d_wr) & ~d_ready.
REQ-016 err  out  1  timeout flag, pulses together with the aborted port's ready.
REQ-017 mem_en / mem_we  out  1 / 1  shared-memory access strobe and write enable, registered.
REQ-018 mem_addr / mem_wdata  out  32 / 32  registered address and write data.
REQ-019 mem_rdata / mem_ack  in  32 / 1  memory read data and completion.

Function
REQ-020 FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE, no request: stay.
- IDLE, request: go to BUSY_IF or BUSY_D; latch the address, write data and direction into the mem_* registers; set mem_en=1 on the same edge.
REQ-021 Arbitration in IDLE:
- Data wins by default.
- If starve_cnt == STARVE_MAX and if_req=1, fetch wins.
REQ-022 starve_cnt behaviour:
- Increments on each data grant made while if_req=1.
- Clears on each fetch grant.
- Saturates at STARVE_MAX.
REQ-023 d_rd=1 and d_wr=1 together: treated as a store (mem_we=1).
REQ-024 BUSY_x: mem_en, mem_addr, mem_we and mem_wdata are held stable; a timeout counter increments each cycle.
REQ-025 BUSY_x with mem_ack=1 sampled:
- Latch mem_rdata into the granted port's rdata.
- Go to RESP; drop mem_en on the same edge.
REQ-026 BUSY_x with counter == TIMEOUT and no ack:
- Go to RESP with err=1 and rdata=0.
- Drop mem_en.
REQ-027 RESP: assert the granted port's ready for exactly one cycle (plus err if it was set), then go to IDLE.
REQ-028 Requester handshake: the requester changes or drops its request at the edge after ready. IDLE therefore never re-grants a completed request.
REQ-029 Minimum latency: request at cycle 0 -> mem_en at cycle 1 -> ack at cycle 1 -> ready at cycle 2. Minimum spacing between accesses is 3 cycles.
REQ-030 rdata outputs hold their last latched value outside RESP; consumers sample them only while ready=1.
REQ-031 mem_ack outside BUSY_x is ignored.
REQ-032 A request that drops while its access is BUSY does not abort the access; it completes normally.

Reset
REQ-033 rstn=0 at an edge forces the following values, regardless of current state:
- state=IDLE, starve_cnt=0, timeout counter=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- if_ready=0, d_ready=0, err=0, if_rdata=0, d_rdata=0.
REQ-034 A reset asserted during BUSY_x or RESP produces no ready or err pulse for the interrupted access.

Structure
REQ-035 The state encodings (IDLE=2'b00, BUSY_IF=2'b01, BUSY_D=2'b10, RESP=2'b11) and grant codes live in the shared encode-definition header beside the CPU control encodings.
REQ-036 The timeout counter is one sub-module, arb_timer, with ports clk, rstn, clear, enable and expired.

Verification
REQ-037 Lone fetch, if_addr=0x100, memory acks on the first BUSY cycle with 0x00500093 -> mem_en at cycle 1, if_ready=1 and if_rdata=0x00500093 at cycle 2.
REQ-038 if_req and d_wr together, d_addr=0x2000, d_wdata=0xDEADBEEF -> data granted first with mem_we=1; fetch is granted after d_ready.
REQ-039 d_rd held continuously plus if_req, STARVE_MAX=4 -> exactly 4 data grants, then one fetch grant, then starve_cnt=0.
REQ-040 mem_ack never asserted, TIMEOUT=15 -> mem_en drops after 15 BUSY cycles; d_ready=1, err=1 and d_rdata=0 for one cycle.
REQ-041 rstn=0 during BUSY_D -> next cycle: mem_en=0, state IDLE, no d_ready pulse; a later ack is ignored.
REQ-042 d_rd=1 and d_wr=1 together -> mem_we=1; d_ready pulses once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states, grant
// codes and bus widths.
package mem_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_D  = 2'b10,
        RESP    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IF   = 2'b01,
        GNT_D    = 2'b10
    } gnt_t;

    function automatic logic is_busy(input state_t s);
        return (s == BUSY_IF) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and shared-memory port of the arbiter.
// Handshake: a requester raises its request and holds it (with address/data stable)
// until the matching ready pulses for one cycle; it changes or drops the request at
// the edge after ready. Memory side: mem_en is held for the whole access and mem_ack
// completes it; mem_rdata is sampled in the same cycle as mem_ack.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ready;
    logic            if_stall;

    logic            d_rd;
    logic            d_wr;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_ready;
    logic            d_stall;

    logic            err;

    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall, err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall, err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Access timeout counter: cleared when an access is granted, counts BUSY cycles,
// and flags the last BUSY cycle an access may occupy before it is aborted.
module arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // r_cnt holds the number of BUSY cycles already completed, so the TIMEOUT-th
    // BUSY cycle is the one where it reads TIMEOUT-1.
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter onto a single shared memory, with data priority,
// fetch starvation protection and an access timeout.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4,
    localparam int SW        = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arb_if.slave      bus,
    output state_t        o_state,
    output logic [SW-1:0] o_starve_cnt
);

    state_t          r_state;
    state_t          w_next_state;
    gnt_t            r_gnt;
    logic [SW-1:0]   r_starve;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_err;

    logic            w_any_d;
    logic            w_starved;
    logic            w_grant_if;
    logic            w_grant_d;
    logic            w_ack_done;
    logic            w_timeout;
    logic            w_expired;
    logic            w_busy;

    assign w_any_d   = bus.d_rd | bus.d_wr;
    assign w_starved = (r_starve == SW'(STARVE_MAX));
    assign w_busy    = is_busy(r_state);

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (w_grant_if | w_grant_d),
        .enable  (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins unless the fetch port has been passed over STARVE_MAX times.
                if (w_any_d && !(bus.if_req && w_starved)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (bus.if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = RESP;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_gnt       <= GNT_NONE;
            r_starve    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_grant_d) begin
                r_gnt       <= GNT_D;
                r_mem_en    <= 1'b1;
                r_mem_we    <= bus.d_wr;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                if (bus.if_req && !w_starved) begin
                    r_starve <= r_starve + SW'(1);
                end
            end
            if (w_grant_if) begin
                r_gnt       <= GNT_IF;
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
                r_starve    <= '0;
            end
            if (w_ack_done || w_timeout) begin
                r_mem_en <= 1'b0;
                if (r_gnt == GNT_IF) begin
                    r_if_rdata <= w_timeout ? '0 : bus.mem_rdata;
                end else begin
                    r_d_rdata  <= w_timeout ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_ready  = (r_state == RESP) && (r_gnt == GNT_IF);
    assign bus.d_ready   = (r_state == RESP) && (r_gnt == GNT_D);
    assign bus.if_stall  = bus.if_req & ~bus.if_ready;
    assign bus.d_stall   = w_any_d & ~bus.d_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = r_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign o_state      = r_state;
    assign o_starve_cnt = r_starve;

endmodule

// File: tb/tb_mem_arb.sv
// Directed scoreboard bench for mem_arb: expected responses and memory accesses are
// queued by the stimulus and checked by independent monitor/memory processes.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int TIMEOUT    = 15;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus ();
    state_t    dbg_state;
    logic [2:0] dbg_starve;

    mem_arb #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .o_state      (dbg_state),
        .o_starve_cnt (dbg_starve)
    );

    resp_t       if_exp_q[$];
    resp_t       d_exp_q[$];
    acc_t        acc_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int   n_vec     = 0;
    int   n_err     = 0;
    int   ack_delay = 0;
    logic force_ack = 1'b0;
    int   busy_n    = 0;
    int   last_len  = 0;
    logic prev_en   = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.if_ready) begin
                if (if_exp_q.size() == 0) begin
                    check("if_ready_unexpected", 1, 0);
                end else begin
                    resp_t e;
                    e = if_exp_q.pop_front();
                    check("if_rdata", bus.if_rdata, e.rdata);
                    check("if_err", bus.err, e.err);
                    check("if_stall_at_ready", bus.if_stall, 0);
                end
            end
            if (bus.d_ready) begin
                if (d_exp_q.size() == 0) begin
                    check("d_ready_unexpected", 1, 0);
                end else begin
                    resp_t e;
                    e = d_exp_q.pop_front();
                    check("d_rdata", bus.d_rdata, e.rdata);
                    check("d_err", bus.err, e.err);
                    check("d_stall_at_ready", bus.d_stall, 0);
                end
            end
        end
    end

    // Memory model: checks each new access against the expected grant order and acks.
    always @(negedge clk) begin
        if (bus.mem_en) begin
            if (!prev_en) begin
                if (acc_q.size() == 0) begin
                    check("mem_access_unexpected", 1, 0);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check("mem_access", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, e);
                end
                if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
            end
            busy_n++;
            if (ack_delay >= 0 && busy_n > ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = bus.mem_we ? 32'h0 :
                                (mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'hBAD0_0000);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0;
            end
        end else begin
            if (prev_en) last_len = busy_n;
            busy_n        = 0;
            bus.mem_ack   = force_ack;
            bus.mem_rdata = force_ack ? 32'hFFFF_FFFF : 32'h0;
        end
        prev_en = bus.mem_en;
    end

    task automatic fetch(input logic [31:0] addr);
        bit seen = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.if_ready) seen = 1;
        end
        if (!seen) check("if_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic d_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rd, input logic wr, input logic keep);
        bit seen = 0;
        bus.d_rd    = rd;
        bus.d_wr    = wr;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.d_ready) seen = 1;
        end
        if (!seen) check("d_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) begin
            bus.d_rd = 1'b0;
            bus.d_wr = 1'b0;
        end
    endtask

    task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        acc_q.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    task automatic push_if(input logic err, input logic [31:0] rdata);
        if_exp_q.push_back('{err: err, rdata: rdata});
    endtask

    task automatic push_d(input logic err, input logic [31:0] rdata);
        d_exp_q.push_back('{err: err, rdata: rdata});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] starve_dat [5];
        starve_dat = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};

        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        mem_model[32'h100] = 32'h0050_0093;
        mem_model[32'h104] = 32'h00A0_0113;
        mem_model[32'h200] = 32'h0000_0013;
        for (int i = 0; i < 5; i++) mem_model[32'h500 + 32'(4 * i)] = starve_dat[i];

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_starve", dbg_starve, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_ready", bus.if_ready, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_err", bus.err, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Lone fetch at minimum latency
        push_acc(1'b0, 32'h100, 32'h0);
        push_if(1'b0, 32'h0050_0093);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        check("lat_c0_mem_en", bus.mem_en, 0);
        check("lat_c0_if_stall", bus.if_stall, 1);
        @(negedge clk);
        check("lat_c1_mem_en", bus.mem_en, 1);
        check("lat_c1_state", dbg_state, BUSY_IF);
        @(negedge clk);
        check("lat_c2_if_ready", bus.if_ready, 1);
        check("lat_c2_mem_en", bus.mem_en, 0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Simultaneous store and fetch: store first, fetch after d_ready
        push_acc(1'b1, 32'h2000, 32'hDEAD_BEEF);
        push_acc(1'b0, 32'h104, 32'h0);
        push_d(1'b0, 32'h0);
        push_if(1'b0, 32'h00A0_0113);
        fork
            fetch(32'h104);
            d_access(32'h2000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        join
        push_acc(1'b0, 32'h2000, 32'h0);
        push_d(1'b0, 32'hDEAD_BEEF);
        d_access(32'h2000, 32'h0, 1'b1, 1'b0, 1'b0);

        // Load and store together behave as a store
        push_acc(1'b1, 32'h3000, 32'h1234_5678);
        push_d(1'b0, 32'h0);
        d_access(32'h3000, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        push_acc(1'b0, 32'h3000, 32'h0);
        push_d(1'b0, 32'h1234_5678);
        d_access(32'h3000, 32'h0, 1'b1, 1'b0, 1'b0);

        // Continuous loads against a waiting fetch: four data grants, then the fetch
        for (int i = 0; i < 4; i++) push_acc(1'b0, 32'h500 + 32'(4 * i), 32'h0);
        push_acc(1'b0, 32'h200, 32'h0);
        push_acc(1'b0, 32'h510, 32'h0);
        for (int i = 0; i < 5; i++) push_d(1'b0, starve_dat[i]);
        push_if(1'b0, 32'h0000_0013);
        fork
            begin
                fetch(32'h200);
                check("starve_after_fetch", dbg_starve, 0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    d_access(32'h500 + 32'(4 * i), 32'h0, 1'b1, 1'b0, i < 4);
                    if (i == 3) check("starve_saturated", dbg_starve, 4);
                end
            end
        join

        // No ack: abort after TIMEOUT busy cycles with err and zero data
        ack_delay = -1;
        push_acc(1'b0, 32'h40, 32'h0);
        push_d(1'b1, 32'h0);
        d_access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        check("timeout_busy_len", last_len, TIMEOUT);

        // Reset in the middle of a data access
        push_acc(1'b0, 32'h600, 32'h0);
        bus.d_rd   = 1'b1;
        bus.d_addr = 32'h600;
        repeat (3) @(negedge clk);
        check("midrst_state_before", dbg_state, BUSY_D);
        check("midrst_mem_en_before", bus.mem_en, 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.d_rd = 1'b0;
        @(negedge clk);
        check("midrst_mem_en", bus.mem_en, 0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_d_ready", bus.d_ready, 0);
        check("midrst_err", bus.err, 0);
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_ack_state", dbg_state, IDLE);
        check("stray_ack_mem_en", bus.mem_en, 0);
        force_ack = 1'b0;
        ack_delay = 0;

        repeat (4) @(negedge clk);
        check("if_queue_drained", if_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);
        check("acc_queue_drained", acc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
